// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Mode encodings, default parameter values and the config address width function.
package clk_div_pkg;

   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_PULSE  = 1'b1;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_CNT_W  = 32;
   localparam int DEF_DIV    = 50_000_000;

   // Address width for n channels, never narrower than one bit.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: holds its own div/mode/en settings, counter and output registers.
// load_i takes priority over sync_i, which takes priority over counting.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int               CNT_W       = DEF_CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEF_DIV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             sync_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic             mode_i,
   input  logic             en_i,
   output logic             out_o,
   output logic             tick_o
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             en_q, en_d;
   logic             out_q, out_d;
   logic             tick_q, tick_d;

   always_comb begin
      div_d  = div_q;
      mode_d = mode_q;
      en_d   = en_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      tick_d = 1'b0;
      if (load_i) begin
         div_d  = div_i;
         mode_d = mode_i;
         en_d   = en_i;
         cnt_d  = '0;
         out_d  = 1'b0;
      end else if (sync_i || (div_q == '0)) begin
         // div=0 parks the channel idle instead of dividing by zero
         cnt_d = '0;
         out_d = 1'b0;
      end else if (en_q) begin
         if (cnt_q >= div_q - ONE) begin
            cnt_d = '0;
            if (mode_q == MODE_PULSE) begin
               tick_d = 1'b1;
               out_d  = 1'b0;
            end else begin
               out_d = ~out_q;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= DEFAULT_DIV;
         mode_q <= MODE_TOGGLE;
         en_q   <= 1'b1;
         cnt_q  <= '0;
         out_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         mode_q <= mode_d;
         en_q   <= en_d;
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         tick_q <= tick_d;
      end
   end

   assign out_o  = out_q;
   assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH clk_div_ch instances plus config decode.
// Optional CLK_DIV_SYNC_EN adds a sync input that restarts every channel at once.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int               NUM_CH      = DEF_NUM_CH,
   parameter int               CNT_W       = DEF_CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEF_DIV),
   parameter int               ADDR_W      = addr_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              cfg_mode,
   input  logic              cfg_en,
`ifdef CLK_DIV_SYNC_EN
   input  logic              sync,
`endif
   output logic [NUM_CH-1:0] out,
   output logic [NUM_CH-1:0] tick
);

   logic              sync_all;
   logic [NUM_CH-1:0] load;

`ifdef CLK_DIV_SYNC_EN
   assign sync_all = sync;
`else
   assign sync_all = 1'b0;
`endif

   // Addresses with no matching channel produce no strobe, so they are ignored.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = cfg_we && (cfg_addr == ADDR_W'(i));

      clk_div_ch #(
         .CNT_W      (CNT_W),
         .DEFAULT_DIV(DEFAULT_DIV)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .load_i (load[i]),
         .sync_i (sync_all),
         .div_i  (cfg_div),
         .mode_i (cfg_mode),
         .en_i   (cfg_en),
         .out_o  (out[i]),
         .tick_o (tick[i])
      );
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (DEFAULT_DIV=4, NUM_CH=4, plus a NUM_CH=3 copy for address decode).
module tb_clk_div_multi;
   import clk_div_pkg::*;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_we = 1'b0, cfg_we3 = 1'b0;
   logic [1:0]       cfg_addr = '0, cfg_addr3 = '0;
   logic [CNT_W-1:0] cfg_div = '0;
   logic             cfg_mode = 1'b0;
   logic             cfg_en = 1'b0;
   logic             sync = 1'b0;
   logic [3:0]       out, tick;
   logic [2:0]       out3, tick3;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int b0, b1, b2, b3, bs;

   always #5 clk = ~clk;

   clk_div_multi #(.NUM_CH(4), .CNT_W(CNT_W), .DEFAULT_DIV(8'd4)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_div(cfg_div),
      .cfg_mode(cfg_mode), .cfg_en(cfg_en),
`ifdef CLK_DIV_SYNC_EN
      .sync(sync),
`endif
      .out(out), .tick(tick)
   );

   clk_div_multi #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_DIV(8'd4)) dut3 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_addr(cfg_addr3), .cfg_div(cfg_div),
      .cfg_mode(cfg_mode), .cfg_en(cfg_en),
`ifdef CLK_DIV_SYNC_EN
      .sync(1'b0),
`endif
      .out(out3), .tick(tick3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wr(input int a, input int div, input logic mode, input logic en);
      cfg_we   = 1'b1;
      cfg_addr = 2'(a);
      cfg_div  = CNT_W'(div);
      cfg_mode = mode;
      cfg_en   = en;
      step();
      cfg_we   = 1'b0;
   endtask

   // Toggle output of a div=4 channel that restarted from zero at cycle b.
   function automatic logic tog4(input int b);
      return 1'((((cyc - b) / 4) % 2) != 0);
   endfunction

   initial begin
      // Reset
      repeat (2) step();
      chk("rst_out", 32'(out), 0);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_out3", 32'(out3), 0);
      rst = 1'b0;
      cyc = 0;

      // T1: all channels at the default divisor, rise at 4, period 8
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("t1_out", 32'(out), 32'({4{tog4(0)}}));
         chk("t1_tick", 32'(tick), 0);
      end

      // T2: ch1 pulse div=3, ch0 untouched
      wr(1, 3, MODE_PULSE, 1'b1);
      b1 = cyc;
      chk("t2_load_tick1", 32'(tick[1]), 0);
      for (int j = 1; j <= 9; j++) begin
         step();
         chk("t2_tick1", 32'(tick[1]), 32'(((cyc - b1) % 3) == 0));
         chk("t2_out1", 32'(out[1]), 0);
         chk("t2_out0", 32'(out[0]), 32'(tog4(0)));
         chk("t2_tick0", 32'(tick[0]), 0);
      end

      // T3: ch2 div=0 idle, then div=1 toggles every clock
      wr(2, 0, MODE_TOGGLE, 1'b1);
      repeat (5) begin
         step();
         chk("t3_idle_out2", 32'(out[2]), 0);
         chk("t3_idle_tick2", 32'(tick[2]), 0);
      end
      wr(2, 1, MODE_TOGGLE, 1'b1);
      b2 = cyc;
      for (int j = 1; j <= 6; j++) begin
         step();
         chk("t3_out2", 32'(out[2]), 32'((cyc - b2) % 2));
         chk("t3_tick2", 32'(tick[2]), 0);
      end

      // T4: ch3 disabled for 10 clocks, then re-enabled from zero
      wr(3, 4, MODE_TOGGLE, 1'b0);
      chk("t4_dis_out3", 32'(out[3]), 0);
      repeat (10) begin
         step();
         chk("t4_hold_out3", 32'(out[3]), 0);
         chk("t4_hold_tick3", 32'(tick[3]), 0);
      end
      wr(3, 4, MODE_TOGGLE, 1'b1);
      b3 = cyc;
      for (int j = 1; j <= 9; j++) begin
         step();
         chk("t4_out3", 32'(out[3]), 32'(tog4(b3)));
      end

      // T5a: address 3 on a 3-channel instance has no channel and is ignored
      cfg_we3   = 1'b1;
      cfg_addr3 = 2'd3;
      cfg_div   = CNT_W'(1);
      cfg_mode  = MODE_TOGGLE;
      cfg_en    = 1'b1;
      step();
      cfg_we3   = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         step();
         chk("t5_oob_out3", 32'(out3), 32'({3{tog4(0)}}));
      end

      // T5b: ch0 write on the edge where it would rise: write wins
      while ((cyc % 8) != 3) step();
      wr(0, 4, MODE_TOGGLE, 1'b1);
      b0 = cyc;
      chk("t5_wrap_out0", 32'(out[0]), 0);
      chk("t5_wrap_tick0", 32'(tick[0]), 0);
      for (int j = 1; j <= 8; j++) begin
         step();
         chk("t5_out0", 32'(out[0]), 32'(tog4(b0)));
         chk("t5_out2", 32'(out[2]), 32'((cyc - b2) % 2));
      end

`ifdef CLK_DIV_SYNC_EN
      // T6: sync aligns ch0 div=2 and ch1 div=4 written on different cycles
      wr(0, 2, MODE_PULSE, 1'b1);
      step();
      wr(1, 4, MODE_PULSE, 1'b1);
      step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      bs = cyc;
      chk("t6_sync_tick", 32'(tick), 0);
      chk("t6_sync_out", 32'(out), 0);
      for (int j = 1; j <= 8; j++) begin
         step();
         chk("t6_tick0", 32'(tick[0]), 32'(((cyc - bs) % 2) == 0));
         chk("t6_tick1", 32'(tick[1]), 32'(((cyc - bs) % 4) == 0));
         chk("t6_out2", 32'(out[2]), 32'((cyc - bs) % 2));
         chk("t6_out3", 32'(out[3]), 32'(tog4(bs)));
      end
`endif

      // Reset beats a simultaneous write and restores the default divisor
      rst      = 1'b1;
      cfg_we   = 1'b1;
      cfg_addr = 2'd0;
      cfg_div  = CNT_W'(1);
      cfg_mode = MODE_PULSE;
      step();
      rst    = 1'b0;
      cfg_we = 1'b0;
      b0 = cyc;
      chk("rst_wr_out", 32'(out), 0);
      for (int j = 1; j <= 6; j++) begin
         step();
         chk("rst_wr_out_run", 32'(out), 32'({4{tog4(b0)}}));
         chk("rst_wr_tick_run", 32'(tick), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
